// File: rtl/knn_kbest_if.sv
// Point-stream handshake for knn_kbest: labelled 2-D point with valid/ready and end-of-stream flag.
// The producer drives the point fields; the engine drives in_ready.
interface knn_kbest_if #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LABEL_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic [DATA_W-1:0]  in_x;
   logic [DATA_W-1:0]  in_y;
   logic [LABEL_W-1:0] in_label;
   logic               in_last;

   modport master (
      output in_valid, in_x, in_y, in_label, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_x, in_y, in_label, in_last,
      output in_ready
   );
endinterface

// File: rtl/knn_kbest.sv
// Streaming K-nearest-neighbour engine: squared distance in a 2-stage pipeline, then a
// one-cycle parallel insert into a K-entry list kept sorted by distance, stable on ties.
module knn_kbest #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned K       = 4,
   parameter int unsigned IDX_W   = 8,
   parameter int unsigned LABEL_W = 4,
   parameter int unsigned SEL_W   = (K > 1) ? $clog2(K) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [DATA_W-1:0]   qx,
   input  logic [DATA_W-1:0]   qy,
   knn_kbest_if.slave          pt,
   output logic                busy,
   output logic                done,
   input  logic [SEL_W-1:0]    rd_sel,
   output logic                rd_valid,
   output logic [2*DATA_W:0]   rd_d2,
   output logic [IDX_W-1:0]    rd_idx,
   output logic [LABEL_W-1:0]  rd_label
);

   localparam int unsigned D2_W = 2 * DATA_W + 1;
   localparam int unsigned P_W  = $clog2(K + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e             state_q;
   logic [DATA_W-1:0]  qx_q, qy_q;
   logic [IDX_W-1:0]   idx_q;
   logic               xfer;

   logic                     s1_valid, s1_last;
   logic signed [DATA_W:0]   s1_dx, s1_dy;
   logic [IDX_W-1:0]         s1_idx;
   logic [LABEL_W-1:0]       s1_label;
   logic                     s2_valid, s2_last;
   logic [D2_W-1:0]          s2_d2;
   logic [IDX_W-1:0]         s2_idx;
   logic [LABEL_W-1:0]       s2_label;

   logic signed [DATA_W:0]     dx, dy;
   logic signed [2*DATA_W+1:0] dx_ext, dy_ext, sq_x, sq_y;
   logic [D2_W-1:0]            d2;

   logic               sl_valid   [K];
   logic [D2_W-1:0]    sl_d2      [K];
   logic [IDX_W-1:0]   sl_idx     [K];
   logic [LABEL_W-1:0] sl_label   [K];
   logic               prev_valid [K];
   logic [D2_W-1:0]    prev_d2    [K];
   logic [IDX_W-1:0]   prev_idx   [K];
   logic [LABEL_W-1:0] prev_label [K];
   logic [P_W-1:0]     pos;
   logic               sel_ok;

   assign pt.in_ready = (state_q == StRun) && !start;
   assign xfer        = pt.in_valid && pt.in_ready;

   always_ff @(posedge clk) begin : p_fsm
      if (rst) begin
         state_q <= StIdle;
         busy    <= 1'b0;
         done    <= 1'b0;
         qx_q    <= '0;
         qy_q    <= '0;
         idx_q   <= '0;
      end else begin
         done <= 1'b0;
         if (start) begin
            state_q <= StRun;
            busy    <= 1'b1;
            qx_q    <= qx;
            qy_q    <= qy;
            idx_q   <= '0;
         end else begin
            if (xfer) idx_q <= idx_q + IDX_W'(1);
            case (state_q)
               StRun:   if (xfer && pt.in_last) state_q <= StDrain;
               // The last point leaves stage 2 on this edge, so the list is final next cycle.
               StDrain: if (s2_valid && s2_last) begin
                  state_q <= StDone;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign dx     = $signed({pt.in_x[DATA_W-1], pt.in_x}) - $signed({qx_q[DATA_W-1], qx_q});
   assign dy     = $signed({pt.in_y[DATA_W-1], pt.in_y}) - $signed({qy_q[DATA_W-1], qy_q});
   assign dx_ext = $signed({{(DATA_W + 1){s1_dx[DATA_W]}}, s1_dx});
   assign dy_ext = $signed({{(DATA_W + 1){s1_dy[DATA_W]}}, s1_dy});
   assign sq_x   = dx_ext * dx_ext;
   assign sq_y   = dy_ext * dy_ext;
   // Each square is below 2^(2*DATA_W), so the sum fits D2_W bits exactly.
   assign d2     = sq_x[D2_W-1:0] + sq_y[D2_W-1:0];

   always_ff @(posedge clk) begin : p_pipe
      if (rst || start) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= xfer;
         s2_valid <= s1_valid;
      end
      s1_last  <= pt.in_last;
      s1_dx    <= dx;
      s1_dy    <= dy;
      s1_idx   <= idx_q;
      s1_label <= pt.in_label;
      s2_last  <= s1_last;
      s2_d2    <= d2;
      s2_idx   <= s1_idx;
      s2_label <= s1_label;
   end

   // Valid slots form a sorted prefix, so counting "<=" hits gives the stable insert point.
   always_comb begin
      pos = '0;
      for (int i = 0; i < K; i++) begin
         if (sl_valid[i] && (sl_d2[i] <= s2_d2)) pos = pos + P_W'(1);
      end
   end

   for (genvar i = 0; i < K; i++) begin : g_prev
      if (i == 0) begin : g_head
         assign prev_valid[i] = 1'b0;
         assign prev_d2[i]    = '0;
         assign prev_idx[i]   = '0;
         assign prev_label[i] = '0;
      end else begin : g_tail
         assign prev_valid[i] = sl_valid[i-1];
         assign prev_d2[i]    = sl_d2[i-1];
         assign prev_idx[i]   = sl_idx[i-1];
         assign prev_label[i] = sl_label[i-1];
      end
   end

   always_ff @(posedge clk) begin : p_slots
      if (rst || start) begin
         for (int i = 0; i < K; i++) begin
            sl_valid[i] <= 1'b0;
            sl_d2[i]    <= '0;
            sl_idx[i]   <= '0;
            sl_label[i] <= '0;
         end
      end else if (s2_valid) begin
         for (int i = 0; i < K; i++) begin
            if (P_W'(i) == pos) begin
               sl_valid[i] <= 1'b1;
               sl_d2[i]    <= s2_d2;
               sl_idx[i]   <= s2_idx;
               sl_label[i] <= s2_label;
            end else if (P_W'(i) > pos) begin
               sl_valid[i] <= prev_valid[i];
               sl_d2[i]    <= prev_d2[i];
               sl_idx[i]   <= prev_idx[i];
               sl_label[i] <= prev_label[i];
            end
         end
      end
   end

   if ((1 << SEL_W) > K) begin : g_sel_guard
      assign sel_ok = (32'(rd_sel) < K);
   end else begin : g_sel_full
      assign sel_ok = 1'b1;
   end

   always_comb begin
      rd_valid = 1'b0;
      rd_d2    = '0;
      rd_idx   = '0;
      rd_label = '0;
      if (sel_ok) begin
         rd_valid = sl_valid[rd_sel];
         rd_d2    = sl_d2[rd_sel];
         rd_idx   = sl_idx[rd_sel];
         rd_label = sl_label[rd_sel];
      end
   end

endmodule

// File: tb/tb_knn_kbest.sv
// Bench for knn_kbest: a queue-based nearest-neighbour model checked every cycle, plus
// directed scenarios with hand-computed slot contents and done latency.
module tb_knn_kbest;

   localparam int DATA_W  = 8;
   localparam int K       = 4;
   localparam int IDX_W   = 8;
   localparam int LABEL_W = 4;
   localparam int SEL_W   = 2;
   localparam int D2_W    = 2 * DATA_W + 1;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic [DATA_W-1:0]  qx = '0;
   logic [DATA_W-1:0]  qy = '0;
   logic               busy, done;
   logic [SEL_W-1:0]   rd_sel = '0;
   logic               rd_valid;
   logic [D2_W-1:0]    rd_d2;
   logic [IDX_W-1:0]   rd_idx;
   logic [LABEL_W-1:0] rd_label;

   knn_kbest_if #(.DATA_W(DATA_W), .LABEL_W(LABEL_W)) pt_if ();

   knn_kbest #(.DATA_W(DATA_W), .K(K), .IDX_W(IDX_W), .LABEL_W(LABEL_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .qx       (qx),
      .qy       (qy),
      .pt       (pt_if),
      .busy     (busy),
      .done     (done),
      .rd_sel   (rd_sel),
      .rd_valid (rd_valid),
      .rd_d2    (rd_d2),
      .rd_idx   (rd_idx),
      .rd_label (rd_label)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: every accepted point since the last start/rst, with its acceptance cycle.
   typedef struct {
      longint d2;
      int     idx;
      int     label;
      int     t;
   } pt_t;

   pt_t    pts[$];
   pt_t    np;
   int     cyc = 0;
   int     phase = 0;    // 0 idle, 1 run, 2 drain, 3 done
   int     done_at = -1;
   int     m_idx = 0;
   int     mqx = 0, mqy = 0;
   longint mdx, mdy;

   always @(posedge clk) begin
      if (rst) begin
         phase = 0; pts.delete(); m_idx = 0; mqx = 0; mqy = 0; done_at = -1;
      end else if (start) begin
         phase = 1; pts.delete(); m_idx = 0; done_at = -1;
         mqx = $signed(qx);
         mqy = $signed(qy);
      end else if (phase == 1) begin
         if (pt_if.in_valid) begin
            mdx = longint'($signed(pt_if.in_x)) - mqx;
            mdy = longint'($signed(pt_if.in_y)) - mqy;
            np.d2 = mdx * mdx + mdy * mdy;
            np.idx = m_idx;
            np.label = int'(pt_if.in_label);
            np.t = cyc;
            pts.push_back(np);
            m_idx = (m_idx + 1) % 256;
            if (pt_if.in_last) begin
               phase = 2;
               done_at = cyc + 3;
            end
         end
      end else if (phase == 2 && cyc + 1 == done_at) begin
         phase = 3;
      end
      cyc++;
   end

   // Compare process: owns rd_sel, snapshots every slot each cycle for the directed checks.
   bit          check_en = 1'b0;
   int          dut_done_cyc = -1;
   int          done_cnt = 0;
   logic [63:0] s_valid [K];
   logic [63:0] s_d2    [K];
   logic [63:0] s_idx   [K];
   bit          e_v     [K];
   longint      e_d2    [K];
   int          e_idx   [K];
   int          e_lab   [K];
   int          elig[$];
   int          best;

   always @(negedge clk) begin
      if (check_en) begin
         chk("in_ready", pt_if.in_ready, (phase == 1) && !start);
         chk("busy", busy, (phase == 1) || (phase == 2));
         chk("done", done, (phase == 3) && (cyc == done_at));
         if (done === 1'b1) begin
            dut_done_cyc = cyc;
            done_cnt++;
         end
         elig.delete();
         foreach (pts[j]) if (pts[j].t <= cyc - 3) elig.push_back(j);
         for (int s = 0; s < K; s++) begin
            if (elig.size() == 0) begin
               e_v[s] = 1'b0; e_d2[s] = 0; e_idx[s] = 0; e_lab[s] = 0;
            end else begin
               best = 0;
               foreach (elig[j]) if (pts[elig[j]].d2 < pts[elig[best]].d2) best = j;
               e_v[s] = 1'b1;
               e_d2[s] = pts[elig[best]].d2;
               e_idx[s] = pts[elig[best]].idx;
               e_lab[s] = pts[elig[best]].label;
               elig.delete(best);
            end
         end
         for (int s = 0; s < K; s++) begin
            rd_sel = SEL_W'(s);
            #1;
            chk($sformatf("slot%0d_valid", s), rd_valid, e_v[s]);
            chk($sformatf("slot%0d_d2", s), rd_d2, e_d2[s]);
            chk($sformatf("slot%0d_idx", s), rd_idx, e_idx[s]);
            chk($sformatf("slot%0d_label", s), rd_label, e_lab[s]);
            s_valid[s] = rd_valid;
            s_d2[s] = rd_d2;
            s_idx[s] = rd_idx;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_start(input int x, input int y);
      start = 1'b1;
      qx = x[DATA_W-1:0];
      qy = y[DATA_W-1:0];
      dut_done_cyc = -1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input int x, input int y, input int lab, input bit last, output int t);
      pt_if.in_valid = 1'b1;
      pt_if.in_x = x[DATA_W-1:0];
      pt_if.in_y = y[DATA_W-1:0];
      pt_if.in_label = lab[LABEL_W-1:0];
      pt_if.in_last = last;
      t = cyc;
      tick();
      pt_if.in_valid = 1'b0;
      pt_if.in_last = 1'b0;
   endtask

   task automatic lit_slot(input string tag, input int s, input bit v, input longint d2,
                           input int idx);
      chk($sformatf("%s_s%0d_valid", tag, s), s_valid[s], v);
      if (v) begin
         chk($sformatf("%s_s%0d_d2", tag, s), s_d2[s], d2);
         chk($sformatf("%s_s%0d_idx", tag, s), s_idx[s], idx);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int t;
   int n0;

   initial begin
      pt_if.in_valid = 1'b0;
      pt_if.in_x = '0;
      pt_if.in_y = '0;
      pt_if.in_label = '0;
      pt_if.in_last = 1'b0;
      tick();
      check_en = 1'b1;
      tick();
      rst = 1'b0;
      // Points offered in IDLE are ignored.
      pt_if.in_valid = 1'b1;
      pt_if.in_x = 8'd1;
      wait_cycles(2);
      chk("idle_ready", pt_if.in_ready, 1'b0);
      pt_if.in_valid = 1'b0;

      // Basic stream, fifth candidate (d2=50) discarded.
      do_start(0, 0);
      send(3, 4, 1, 1'b0, t);
      send(1, 1, 2, 1'b0, t);
      send(-2, 0, 3, 1'b0, t);
      send(5, 5, 4, 1'b0, t);
      send(0, 1, 5, 1'b1, t);
      wait_cycles(5);
      chk("t1_done_lat", 64'(dut_done_cyc - t), 3);
      lit_slot("t1", 0, 1, 1, 4);
      lit_slot("t1", 1, 1, 2, 1);
      lit_slot("t1", 2, 1, 4, 2);
      lit_slot("t1", 3, 1, 25, 0);

      // Single point with in_last.
      do_start(2, 0);
      send(4, 0, 7, 1'b1, t);
      wait_cycles(5);
      chk("t2_done_lat", 64'(dut_done_cyc - t), 3);
      lit_slot("t2", 0, 1, 4, 0);
      lit_slot("t2", 1, 0, 0, 0);
      lit_slot("t2", 3, 0, 0, 0);

      // Equal distances keep arrival order.
      do_start(0, 0);
      send(1, 0, 1, 1'b0, t);
      send(0, 1, 2, 1'b0, t);
      send(-1, 0, 3, 1'b1, t);
      wait_cycles(5);
      lit_slot("t3", 0, 1, 1, 0);
      lit_slot("t3", 1, 1, 1, 1);
      lit_slot("t3", 2, 1, 1, 2);
      lit_slot("t3", 3, 0, 0, 0);

      // Extreme coordinates, no wrap in the distance.
      do_start(-128, -128);
      send(127, 127, 0, 1'b1, t);
      wait_cycles(5);
      lit_slot("t4a", 0, 1, 130050, 0);
      do_start(127, 127);
      send(-128, -128, 0, 1'b1, t);
      wait_cycles(5);
      lit_slot("t4b", 0, 1, 130050, 0);

      // Gapped valid; a near point offered through DRAIN and DONE must be ignored.
      do_start(0, 0);
      send(1, 0, 1, 1'b0, t);
      pt_if.in_x = 8'd9;
      tick();
      send(2, 0, 2, 1'b0, t);
      send(3, 0, 3, 1'b1, t);
      pt_if.in_valid = 1'b1;
      pt_if.in_x = '0;
      pt_if.in_y = '0;
      wait_cycles(5);
      chk("t5_done_ready", pt_if.in_ready, 1'b0);
      pt_if.in_valid = 1'b0;
      chk("t5_done_lat", 64'(dut_done_cyc - t), 3);
      lit_slot("t5", 0, 1, 1, 0);
      lit_slot("t5", 1, 1, 4, 1);
      lit_slot("t5", 2, 1, 9, 2);
      lit_slot("t5", 3, 0, 0, 0);

      // 300 points: index wraps, so the two nearest carry idx 0 and 1.
      do_start(0, 0);
      for (int i = 0; i < 300; i++) begin
         if (i == 256)      send(0, 0, i % 16, 1'b0, t);
         else if (i == 257) send(1, 0, i % 16, 1'b0, t);
         else               send(50, 50, i % 16, i == 299, t);
      end
      wait_cycles(5);
      lit_slot("t5c", 0, 1, 0, 0);
      lit_slot("t5c", 1, 1, 1, 1);
      lit_slot("t5c", 2, 1, 5000, 0);
      lit_slot("t5c", 3, 1, 5000, 1);

      // Abort mid-RUN with points in flight.
      do_start(0, 0);
      send(5, 5, 1, 1'b0, t);
      send(6, 6, 2, 1'b0, t);
      send(7, 7, 3, 1'b0, t);
      do_start(1, 1);
      tick();
      lit_slot("t6a_clr", 0, 0, 0, 0);
      lit_slot("t6a_clr", 1, 0, 0, 0);
      send(1, 2, 9, 1'b1, t);
      wait_cycles(5);
      lit_slot("t6a", 0, 1, 1, 0);
      lit_slot("t6a", 1, 0, 0, 0);

      // Reset during DRAIN: done never pulses.
      do_start(0, 0);
      send(1, 1, 1, 1'b1, t);
      n0 = done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_cycles(5);
      chk("t6b_no_done", 64'(done_cnt - n0), 0);
      chk("t6b_busy", busy, 1'b0);
      lit_slot("t6b", 0, 0, 0, 0);

      check_en = 1'b0;
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
